testmem_dp: RTL

TESTMEM_DP -- requirements
Module: testmem_dp

---
 rtl/testmem_pkg.sv | 24 ++
 rtl/testmem_arb.sv | 25 ++
 rtl/testmem_dp.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/testmem_pkg.sv
// -----------------------------------------------------------------------------
// testmem_pkg : shared types and default constants for the dual-port test memory
// -----------------------------------------------------------------------------
package testmem_pkg;

   // Default configuration of testmem_dp
   localparam int DEF_DATA_W      = 36;
   localparam int DEF_ADDR_W      = 18;
   localparam int DEF_DEPTH_LOG2  = 14;
   localparam int DEF_WAIT_CYCLES = 4;

   // Access controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // True when every address bit at or above i_lsb is zero
   function automatic logic f_in_range(input logic [63:0] i_addr, input int unsigned i_lsb);
      return ((i_addr >> i_lsb) == 64'd0);
   endfunction

endpackage : testmem_pkg

// File: rtl/testmem_arb.sv
// -----------------------------------------------------------------------------
// testmem_arb : two-requester round-robin arbiter
//   bit 0 = port A, bit 1 = port B. On a tie the port not served last wins.
// -----------------------------------------------------------------------------
module testmem_arb
   import testmem_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_b,
   output logic [1:0] o_grant
);

   // One-hot grant; a single requester always wins, a tie goes to the other port
   always_comb begin
      o_grant = 2'b00;
      case (i_req)
         2'b00:   o_grant = 2'b00;
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = i_last_b ? 2'b01 : 2'b10;
         default: o_grant = 2'b00;
      endcase
   end

endmodule : testmem_arb

// File: rtl/testmem_dp.sv
// -----------------------------------------------------------------------------
// testmem_dp : dual-port test memory with a single shared access controller
//   Each port is an Avalon-like master interface with a waitrequest stall.
//   One transfer is in flight at a time; contention resolved round-robin.
//   Optional feature macro: TESTMEM_DP_ERRFLAG_EN adds o_err, pulsing for the
//   completion cycle of any out-of-range access.
// -----------------------------------------------------------------------------
module testmem_dp
   import testmem_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
)(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [ADDR_W-1:0] i_a_address,
   input  logic              i_a_write,
   input  logic              i_a_read,
   input  logic [DATA_W-1:0] i_a_writedata,
   output logic [DATA_W-1:0] o_a_readdata,
   output logic              o_a_waitrequest,
   input  logic [ADDR_W-1:0] i_b_address,
   input  logic              i_b_write,
   input  logic              i_b_read,
   input  logic [DATA_W-1:0] i_b_writedata,
   output logic [DATA_W-1:0] o_b_readdata,
   output logic              o_b_waitrequest
`ifdef TESTMEM_DP_ERRFLAG_EN
   ,
   output logic              o_err
`endif
);

   localparam int CNT_W = $clog2(WAIT_CYCLES + 32'sd1);
   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [CNT_W-1:0] LP_CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(WAIT_CYCLES - 32'sd1);

   // Controller state
   state_e            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_last_b;     // 1: port B was served most recently
   logic              r_gnt_b;      // port owning the current transfer (1 = B)
   logic              r_a_wait;
   logic              r_b_wait;
   logic [DATA_W-1:0] r_a_rdata;
   logic [DATA_W-1:0] r_b_rdata;
`ifdef TESTMEM_DP_ERRFLAG_EN
   logic              r_err;
`endif

   // Storage; intentionally not reset
   logic [DATA_W-1:0] r_mem [DEPTH];

   // Combinational helpers
   logic                  w_a_req;
   logic                  w_b_req;
   logic [1:0]            w_arb_grant;
   logic                  w_sel_b;
   logic                  w_sel_write;
   logic                  w_sel_read;
   logic                  w_sel_req;
   logic [ADDR_W-1:0]     w_sel_addr;
   logic [DATA_W-1:0]     w_sel_wdata;
   logic                  w_sel_in_range;
   logic [DEPTH_LOG2-1:0] w_sel_idx;
   logic                  w_enter_done;
   logic                  w_mem_we;
   logic [DATA_W-1:0]     w_rd_word;

   assign w_a_req = i_a_write | i_a_read;
   assign w_b_req = i_b_write | i_b_read;

   testmem_arb u_arb (
      .i_req    ({w_b_req, w_a_req}),
      .i_last_b (r_last_b),
      .o_grant  (w_arb_grant)
   );

   // Port being considered: the arbiter's pick while idle, else the granted owner
   always_comb begin
      w_sel_b = r_gnt_b;
      if (r_state == IDLE) begin
         w_sel_b = w_arb_grant[1];
      end else begin
         w_sel_b = r_gnt_b;
      end
   end

   // Route the selected port's request fields; write wins over read
   always_comb begin
      w_sel_write = 1'b0;
      w_sel_read  = 1'b0;
      w_sel_addr  = {ADDR_W{1'b0}};
      w_sel_wdata = {DATA_W{1'b0}};
      if (w_sel_b) begin
         w_sel_write = i_b_write;
         w_sel_read  = i_b_read & ~i_b_write;
         w_sel_addr  = i_b_address;
         w_sel_wdata = i_b_writedata;
      end else begin
         w_sel_write = i_a_write;
         w_sel_read  = i_a_read & ~i_a_write;
         w_sel_addr  = i_a_address;
         w_sel_wdata = i_a_writedata;
      end
   end

   assign w_sel_req      = w_sel_write | w_sel_read;
   assign w_sel_in_range = f_in_range(64'(w_sel_addr), DEPTH_LOG2);
   assign w_sel_idx      = w_sel_addr[DEPTH_LOG2-1:0];
   assign w_mem_we       = (r_state == DONE) & w_sel_write & w_sel_in_range;

   // Detect the edge on which the controller moves into its completion cycle
   always_comb begin
      w_enter_done = 1'b0;
      case (r_state)
         IDLE:    w_enter_done = (w_arb_grant != 2'b00) && (LP_CNT_LOAD == LP_CNT_ZERO);
         BUSY:    w_enter_done = w_sel_req && (r_cnt == LP_CNT_ONE);
         DONE:    w_enter_done = 1'b0;
         default: w_enter_done = 1'b0;
      endcase
   end

   // Word to present in the completion cycle; zero for writes and out-of-range reads
   always_comb begin
      w_rd_word = {DATA_W{1'b0}};
      if (w_sel_read && w_sel_in_range) begin
         w_rd_word = r_mem[w_sel_idx];
      end else begin
         w_rd_word = {DATA_W{1'b0}};
      end
   end

   // Access controller FSM with registered stall, read data and error outputs
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= IDLE;
         r_cnt     <= LP_CNT_ZERO;
         r_last_b  <= 1'b1;
         r_gnt_b   <= 1'b0;
         r_a_wait  <= 1'b1;
         r_b_wait  <= 1'b1;
         r_a_rdata <= {DATA_W{1'b0}};
         r_b_rdata <= {DATA_W{1'b0}};
`ifdef TESTMEM_DP_ERRFLAG_EN
         r_err     <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_arb_grant != 2'b00) begin
                  r_gnt_b <= w_arb_grant[1];
                  if (LP_CNT_LOAD == LP_CNT_ZERO) begin
                     r_state <= DONE;
                     r_cnt   <= LP_CNT_ZERO;
                  end else begin
                     r_state <= BUSY;
                     r_cnt   <= LP_CNT_LOAD;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            BUSY: begin
               if (!w_sel_req) begin
                  // Owner withdrew: abandon without touching memory or round-robin
                  r_state <= IDLE;
                  r_cnt   <= LP_CNT_ZERO;
               end else if (r_cnt == LP_CNT_ONE) begin
                  r_state <= DONE;
                  r_cnt   <= LP_CNT_ZERO;
               end else begin
                  r_cnt <= r_cnt - LP_CNT_ONE;
               end
            end
            DONE: begin
               r_last_b <= r_gnt_b;
               r_state  <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= LP_CNT_ZERO;
            end
         endcase

         if (w_enter_done) begin
            r_a_wait  <= w_sel_b;
            r_b_wait  <= ~w_sel_b;
            r_a_rdata <= w_sel_b ? {DATA_W{1'b0}} : w_rd_word;
            r_b_rdata <= w_sel_b ? w_rd_word : {DATA_W{1'b0}};
`ifdef TESTMEM_DP_ERRFLAG_EN
            r_err     <= ~w_sel_in_range;
`endif
         end else begin
            r_a_wait  <= 1'b1;
            r_b_wait  <= 1'b1;
            r_a_rdata <= {DATA_W{1'b0}};
            r_b_rdata <= {DATA_W{1'b0}};
`ifdef TESTMEM_DP_ERRFLAG_EN
            r_err     <= 1'b0;
`endif
         end
      end
   end

   // Memory write port, committed at the end of the completion cycle
   always_ff @(posedge i_clk) begin
      if (w_mem_we) begin
         r_mem[w_sel_idx] <= w_sel_wdata;
      end
   end

   assign o_a_waitrequest = r_a_wait;
   assign o_b_waitrequest = r_b_wait;
   assign o_a_readdata    = r_a_rdata;
   assign o_b_readdata    = r_b_rdata;
`ifdef TESTMEM_DP_ERRFLAG_EN
   assign o_err           = r_err;
`endif

endmodule : testmem_dp
